// File: rtl/int_coalescer_if.sv
// Signal bundle between the interrupt coalescer, its event/config source and the router lane.
// master = event/config/router side, slave = coalescer.
interface int_coalescer_if #(
    parameter int CNT_WIDTH = 16,
    parameter int TMR_WIDTH = 16
);
    logic                 event_valid;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CNT_WIDTH-1:0] cfg_threshold;
    logic [TMR_WIDTH-1:0] cfg_timeout;
    logic                 int_valid;
    logic                 int_ready;
    logic [CNT_WIDTH-1:0] pending_count;
    logic [CNT_WIDTH-1:0] stat_last_count;
    logic                 stat_last_ovf;
    logic [31:0]          stat_batches;

    modport master (
        output event_valid, cfg_valid, cfg_threshold, cfg_timeout, int_ready,
        input  cfg_ready, int_valid, pending_count, stat_last_count, stat_last_ovf, stat_batches
    );

    modport slave (
        input  event_valid, cfg_valid, cfg_threshold, cfg_timeout, int_ready,
        output cfg_ready, int_valid, pending_count, stat_last_count, stat_last_ovf, stat_batches
    );
endinterface

// File: rtl/int_coalescer.sv
// Event-count / idle-timeout interrupt coalescer feeding one router interrupt lane.
//   state   | meaning
//   S_IDLE  | no events in batch, no request
//   S_ACCUM | batch open, timer running
//   S_FIRE  | int_valid high, waiting for int_ready
module int_coalescer #(
    parameter int CNT_WIDTH = 16,
    parameter int TMR_WIDTH = 16
) (
    input logic            clk,
    input logic            reset,
    int_coalescer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FIRE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [TMR_WIDTH-1:0] TMR_ONE = TMR_WIDTH'(1);
    localparam logic [TMR_WIDTH-1:0] TMR_MAX = '1;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] thr, thr_eff, count, count_inc, last_count;
    logic [TMR_WIDTH-1:0] tmo, timer;
    logic                 ovf, last_ovf, thr_hit, tmo_hit;
    logic [31:0]          batches;

    assign thr_eff   = (thr == '0) ? CNT_ONE : thr;
    assign thr_hit   = (count >= thr_eff);
    assign tmo_hit   = (tmo != '0) && (timer >= tmo);
    assign count_inc = (count == CNT_MAX) ? CNT_MAX : count + CNT_ONE;

    assign bus.cfg_ready       = 1'b1;
    assign bus.int_valid       = (state == S_FIRE);
    assign bus.pending_count   = count;
    assign bus.stat_last_count = last_count;
    assign bus.stat_last_ovf   = last_ovf;
    assign bus.stat_batches    = batches;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.event_valid) state_nxt = S_ACCUM;
            S_ACCUM: if (thr_hit || tmo_hit) state_nxt = S_FIRE;
            S_FIRE:  if (bus.int_ready) state_nxt = bus.event_valid ? S_ACCUM : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thr <= CNT_ONE;
            tmo <= '0;
        end else if (bus.cfg_valid) begin
            thr <= bus.cfg_threshold;
            tmo <= bus.cfg_timeout;
        end
    end

    // ovf marks an event lost because the counter was already pinned at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            timer      <= '0;
            ovf        <= 1'b0;
            last_count <= '0;
            last_ovf   <= 1'b0;
            batches    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.event_valid) begin
                        count <= CNT_ONE;
                        timer <= '0;
                        ovf   <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (timer != TMR_MAX) timer <= timer + TMR_ONE;
                    if (bus.event_valid) begin
                        count <= count_inc;
                        if (count == CNT_MAX) ovf <= 1'b1;
                    end
                end
                S_FIRE: begin
                    if (bus.int_ready) begin
                        last_count <= count;
                        last_ovf   <= ovf;
                        batches    <= batches + 32'd1;
                        ovf        <= 1'b0;
                        timer      <= '0;
                        count      <= bus.event_valid ? CNT_ONE : '0;
                    end else if (bus.event_valid) begin
                        count <= count_inc;
                        if (count == CNT_MAX) ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_int_coalescer.sv
// Self-checking bench for int_coalescer: vector table, scoreboard on acknowledged batches,
// hand sequences for same-cycle ack/event, ignored acks, mid-batch reconfig, reset and saturation.
module tb_int_coalescer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   n_acks;

    typedef struct {
        int cnt;
        int ovf;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int thr;
        int tmo;
        int n_ev;
        int exp_lat;
        int exp_cnt;
    } vec_t;
    vec_t vecs[8];

    int_coalescer_if #(.CNT_WIDTH(16), .TMR_WIDTH(16)) bus ();
    int_coalescer_if #(.CNT_WIDTH(4),  .TMR_WIDTH(16)) sbus ();

    int_coalescer #(.CNT_WIDTH(16), .TMR_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int_coalescer #(.CNT_WIDTH(4), .TMR_WIDTH(16)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int thr, input int tmo);
        bus.cfg_valid     = 1'b1;
        bus.cfg_threshold = 16'(thr);
        bus.cfg_timeout   = 16'(tmo);
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic do_ack(input int cnt, input int ovf);
        sb_t e;
        e.cnt = cnt;
        e.ovf = ovf;
        sb_q.push_back(e);
        n_acks++;
        bus.int_ready = 1'b1;
        tick();
        bus.int_ready = 1'b0;
        check("ack_drop", 32'(bus.int_valid), 32'd0);
    endtask

    // Scoreboard: every stat_batches step consumes one expected batch
    logic [31:0] mon_batches;
    logic        mon_rst;
    sb_t         mon_e;
    initial mon_batches = '0;
    always @(posedge clk) begin
        mon_rst = reset;
        #1;
        if (mon_rst) begin
            mon_batches = '0;
        end else if (bus.stat_batches !== mon_batches) begin
            mon_batches = mon_batches + 32'd1;
            check("sb_batches", bus.stat_batches, mon_batches);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got batch %0d expected no batch", bus.stat_batches);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_last_count", 32'(bus.stat_last_count), mon_e.cnt);
                check("sb_last_ovf", 32'(bus.stat_last_ovf), mon_e.ovf);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        n_acks   = 0;
        // thr, tmo, events, cycles first-event->int_valid, batch size
        vecs[0] = '{4,   0,  4, 4,  4};
        vecs[1] = '{100, 50, 1, 51, 1};
        vecs[2] = '{1,   0,  1, 1,  1};
        vecs[3] = '{0,   0,  1, 1,  1};
        vecs[4] = '{3,   0,  5, 3,  5};
        vecs[5] = '{10,  3,  2, 4,  2};
        vecs[6] = '{2,   5,  2, 2,  2};
        vecs[7] = '{5,   1,  1, 2,  1};

        reset = 1'b1;
        bus.event_valid = 1'b0; bus.cfg_valid = 1'b0; bus.int_ready = 1'b0;
        bus.cfg_threshold = '0; bus.cfg_timeout = '0;
        sbus.event_valid = 1'b0; sbus.cfg_valid = 1'b0; sbus.int_ready = 1'b0;
        sbus.cfg_threshold = '0; sbus.cfg_timeout = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_int_valid", 32'(bus.int_valid), 32'd0);
        check("rst_pending", 32'(bus.pending_count), 32'd0);
        check("rst_last_count", 32'(bus.stat_last_count), 32'd0);
        check("rst_last_ovf", 32'(bus.stat_last_ovf), 32'd0);
        check("rst_batches", bus.stat_batches, 32'd0);
        check("cfg_ready", 32'(bus.cfg_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            int lat;
            cfg_write(vecs[i].thr, vecs[i].tmo);
            lat = -1;
            for (int t = 0; t < 200; t++) begin
                bus.event_valid = (t < vecs[i].n_ev);
                tick();
                if (bus.int_valid && lat < 0) lat = t;
                if (lat >= 0 && t >= vecs[i].n_ev - 1) break;
            end
            bus.event_valid = 1'b0;
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_pending", i), 32'(bus.pending_count), vecs[i].exp_cnt);
            if (lat >= 0) begin
                do_ack(vecs[i].exp_cnt, 0);
                check($sformatf("v%0d_pending_after_ack", i), 32'(bus.pending_count), 32'd0);
            end
        end

        // Event in the ack cycle opens the next batch
        cfg_write(2, 0);
        bus.event_valid = 1'b1; tick(); tick();
        bus.event_valid = 1'b0; tick();
        check("same_fire", 32'(bus.int_valid), 32'd1);
        bus.event_valid = 1'b1;
        do_ack(2, 0);
        bus.event_valid = 1'b0;
        check("same_pending", 32'(bus.pending_count), 32'd1);
        tick();
        check("same_accum_hold", 32'(bus.int_valid), 32'd0);
        check("same_accum_count", 32'(bus.pending_count), 32'd1);
        bus.event_valid = 1'b1; tick();
        bus.event_valid = 1'b0; tick();
        check("same_refire", 32'(bus.int_valid), 32'd1);
        do_ack(2, 0);

        // Stray acks in IDLE and ACCUM, then threshold lowered mid-batch
        bus.int_ready = 1'b1; tick(); bus.int_ready = 1'b0;
        check("idle_ack_valid", 32'(bus.int_valid), 32'd0);
        check("idle_ack_batches", bus.stat_batches, 32'(n_acks));
        cfg_write(10, 0);
        bus.event_valid = 1'b1; tick(); tick();
        bus.event_valid = 1'b0; bus.int_ready = 1'b1; tick(); bus.int_ready = 1'b0;
        check("accum_ack_pending", 32'(bus.pending_count), 32'd2);
        check("accum_ack_valid", 32'(bus.int_valid), 32'd0);
        check("accum_ack_batches", bus.stat_batches, 32'(n_acks));
        bus.event_valid = 1'b1; tick(); tick(); tick();
        bus.event_valid = 1'b0;
        check("midcfg_pending", 32'(bus.pending_count), 32'd5);
        cfg_write(3, 0);
        check("midcfg_not_yet", 32'(bus.int_valid), 32'd0);
        tick();
        check("midcfg_fire", 32'(bus.int_valid), 32'd1);
        do_ack(5, 0);

        // Reset while requesting
        cfg_write(1, 0);
        bus.event_valid = 1'b1; tick();
        bus.event_valid = 1'b0; tick();
        check("pre_reset_fire", 32'(bus.int_valid), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        n_acks = 0;
        check("post_reset_valid", 32'(bus.int_valid), 32'd0);
        check("post_reset_batches", bus.stat_batches, 32'd0);
        check("post_reset_last", 32'(bus.stat_last_count), 32'd0);
        check("post_reset_pending", 32'(bus.pending_count), 32'd0);

        // 4-bit counter saturation and thr=0
        sbus.cfg_valid = 1'b1; sbus.cfg_threshold = 4'd15; tick(); sbus.cfg_valid = 1'b0;
        sbus.event_valid = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        sbus.event_valid = 1'b0;
        check("sat_fire", 32'(sbus.int_valid), 32'd1);
        check("sat_pending", 32'(sbus.pending_count), 32'd15);
        sbus.int_ready = 1'b1; tick(); sbus.int_ready = 1'b0;
        check("sat_last_count", 32'(sbus.stat_last_count), 32'd15);
        check("sat_last_ovf", 32'(sbus.stat_last_ovf), 32'd1);
        check("sat_batches", sbus.stat_batches, 32'd1);
        check("sat_pending_clr", 32'(sbus.pending_count), 32'd0);
        sbus.cfg_valid = 1'b1; sbus.cfg_threshold = 4'd0; tick(); sbus.cfg_valid = 1'b0;
        sbus.event_valid = 1'b1; tick();
        sbus.event_valid = 1'b0; tick();
        check("thr0_fire", 32'(sbus.int_valid), 32'd1);
        sbus.int_ready = 1'b1; tick(); sbus.int_ready = 1'b0;
        check("thr0_last_count", 32'(sbus.stat_last_count), 32'd1);
        check("thr0_last_ovf", 32'(sbus.stat_last_ovf), 32'd0);
        check("thr0_batches", sbus.stat_batches, 32'd2);

        tick();
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
